// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the PE accumulator sequencer: state encoding and
// default counter widths.
package acc_ctrl_pkg;

    localparam int CW_DEF = 5;
    localparam int KW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } acc_ctrl_state_t;

endpackage

// File: rtl/acc_ctrl_mod_cnt.sv
// Modulo counter: counts 0..max_i with enable and synchronous clear; wrap_o
// flags the enabled cycle on which the count returns to zero.
module mod_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = en_i && (cnt_q == max_i);
    assign cnt_o  = cnt_q;

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/acc_ctrl.sv
// Sequencer for the binary-serial PE accumulator: one clear, then K products
// of C serial cycles each, then a one-cycle result-valid pulse.
module acc_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int KW = KW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic [CW-1:0] i_cfg_cycles,
    input  logic [KW-1:0] i_cfg_k,
    input  logic          i_cfg_chain,
    input  logic          i_stall,
    input  logic          i_abort,
    output logic          o_clr,
    output logic          o_en,
    output logic          o_acc,
    output logic          o_busy,
    output logic          o_valid
);

    acc_ctrl_state_t state_q, state_d;
    logic [CW-1:0]   cfg_cycles_q;
    logic [KW-1:0]   cfg_k_q;
    logic            cfg_chain_q;

    logic [CW-1:0]   cyc, cyc_max;
    logic [KW-1:0]   kc, k_max;
    logic            cyc_wrap, kc_wrap;
    logic            run_adv, cnt_clr, accept, last_product;

    // A configured C of 0 behaves as a single-cycle product.
    assign cyc_max = (cfg_cycles_q == '0) ? '0 : cfg_cycles_q - 1'b1;
    assign k_max   = cfg_k_q - 1'b1;

    assign accept  = (state_q == IDLE) && i_start;
    assign run_adv = (state_q == RUN) && !i_stall && !i_abort;
    assign cnt_clr = (state_q != RUN) || i_abort;

    mod_cnt #(.W(CW)) u_cyc_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (run_adv),
        .clr_i  (cnt_clr),
        .max_i  (cyc_max),
        .cnt_o  (cyc),
        .wrap_o (cyc_wrap)
    );

    mod_cnt #(.W(KW)) u_kc_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (cyc_wrap),
        .clr_i  (cnt_clr),
        .max_i  (k_max),
        .cnt_o  (kc),
        .wrap_o (kc_wrap)
    );

    assign last_product = kc_wrap;

    assign o_busy  = (state_q != IDLE);
    assign o_clr   = (state_q == CLR) && !i_abort;
    assign o_en    = run_adv && (cyc == cyc_max);
    assign o_acc   = o_en && (kc == '0) && cfg_chain_q;
    assign o_valid = (state_q == DONE) && !i_abort;

    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && i_abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (i_start) state_d = CLR;
                CLR:  state_d = (cfg_k_q == '0) ? DONE : RUN;
                RUN:  if (last_product) state_d = DONE;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cfg_cycles_q <= '0;
            cfg_k_q      <= '0;
            cfg_chain_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cfg_cycles_q <= i_cfg_cycles;
                cfg_k_q      <= i_cfg_k;
                cfg_chain_q  <= i_cfg_chain;
            end
        end
    end

endmodule

// File: tb/tb_acc_ctrl.sv
// Scoreboard bench for acc_ctrl: a job-level model predicts the cycle of every
// clr/en/valid pulse and the accumulated result; a monitor compares them.
module tb_acc_ctrl;

    localparam int CW = 5;
    localparam int KW = 16;
    localparam int NONE = 32'h7fff_ffff;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [CW-1:0] i_cfg_cycles = '0;
    logic [KW-1:0] i_cfg_k = '0;
    logic          i_cfg_chain = 1'b0;
    logic          i_stall = 1'b0;
    logic          i_abort = 1'b0;
    logic          o_clr, o_en, o_acc, o_busy, o_valid;

    acc_ctrl #(.CW(CW), .KW(KW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_cfg_cycles (i_cfg_cycles),
        .i_cfg_k      (i_cfg_k),
        .i_cfg_chain  (i_cfg_chain),
        .i_stall      (i_stall),
        .i_abort      (i_abort),
        .o_clr        (o_clr),
        .o_en         (o_en),
        .o_acc        (o_acc),
        .o_busy       (o_busy),
        .o_valid      (o_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        logic [3:0] vec;   // {clr, en, acc, valid}
        int       res;
    } ev_t;

    ev_t exp_q[$];
    int  cyc_cnt = 0;
    int  errors = 0;
    int  checks = 0;
    int  data0 = 0;
    int  data1 = 0;
    int  acc_m = 0;
    bit  stl[512];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Behavioural accumulator driven by the sequencer's controls.
    always @(posedge clk) begin
        if (o_clr) acc_m <= 0;
        else if (o_en) acc_m <= (o_acc ? data0 : acc_m) + data1;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc_cnt);
        end
    endtask

    // Monitor: every pulse must match the head of the expected-event queue.
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
                ev_t m;
                m = exp_q.pop_front();
                check("missed_event_cycle", NONE, m.cyc);
            end
            if (o_clr || o_en || o_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse_vec", int'({o_clr, o_en, o_acc, o_valid}), 0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("event_cycle", cyc_cnt, e.cyc);
                    check("event_vec", int'({o_clr, o_en, o_acc, o_valid}), int'(e.vec));
                    if (e.vec[0]) check("result", acc_m, e.res);
                end
            end else if (o_acc) begin
                check("acc_without_en", 1, 0);
            end
        end
    end

    // Reference: walk the unstalled run cycles; every C-th one closes a product.
    // Events at or after cut (abort/reset cycle) are never produced. Returns valid cycle.
    function automatic int predict(int s, int c, int k, bit ch, int cut);
        int ce, n, j, t;
        ev_t e;
        ce = (c == 0) ? 1 : c;
        e.res = 0;
        if (s < cut) begin e.cyc = s; e.vec = 4'b1000; exp_q.push_back(e); end
        t = s;
        n = 0;
        j = 0;
        while (j < k) begin
            t++;
            if (!((t - s) < 512 && stl[t - s])) begin
                n++;
                if (n % ce == 0) begin
                    if (t < cut) begin
                        e.cyc = t;
                        e.vec = {2'b01, (j == 0 && ch), 1'b0};
                        exp_q.push_back(e);
                    end
                    j++;
                end
            end
        end
        t++;
        if (t < cut) begin
            e.cyc = t;
            e.vec = 4'b0001;
            e.res = (k == 0) ? 0 : (ch ? data0 : 0) + k * data1;
            exp_q.push_back(e);
        end
        return t;
    endfunction

    // Called at ~#3 after a posedge with the DUT idle; abort_r/rst_r are
    // relative cycle numbers (1 = CLR cycle) or 0 for none.
    task automatic run_job(input int c, input int k, input bit ch, input bit hold,
                           input int abort_r, input int rst_r);
        int s, v, end_cyc, a_cyc, r_cyc, cut;
        check("idle_before_start", int'(o_busy), 0);
        i_cfg_cycles = CW'(c);
        i_cfg_k      = KW'(k);
        i_cfg_chain  = ch;
        i_start      = 1'b1;
        @(posedge clk);
        #1;
        s     = cyc_cnt;
        a_cyc = (abort_r > 0) ? s + abort_r - 1 : NONE;
        r_cyc = (rst_r > 0) ? s + rst_r - 1 : NONE;
        cut   = (a_cyc < r_cyc) ? a_cyc : r_cyc;
        v     = predict(s, c, k, ch, cut);
        end_cyc = (v < cut) ? v : cut;
        i_cfg_cycles = CW'($urandom);
        i_cfg_k      = KW'($urandom);
        i_cfg_chain  = 1'($urandom);
        for (int t = s; ; t++) begin
            i_stall = ((t - s) < 512) ? stl[t - s] : 1'b0;
            i_abort = (t == a_cyc);
            i_start = hold && (t < s + 3) && (t < end_cyc);
            if (t == r_cyc) begin
                #1 rst_n = 1'b0;
                #1 check("reset_outputs", int'({o_clr, o_en, o_acc, o_busy, o_valid}), 0);
            end
            if (t >= end_cyc) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_stall = 1'b0;
        i_abort = 1'b0;
        rst_n   = 1'b1;
        #1 check("idle_after_job", int'(o_busy), 0);
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < 512; i++) stl[i] = 1'b0;
    endtask

    initial begin
        #2 check("reset_outputs_init", int'({o_clr, o_en, o_acc, o_busy, o_valid}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #3 check("idle_outputs", int'({o_clr, o_en, o_acc, o_busy, o_valid}), 0);

        clear_stalls();
        data0 = 0;   data1 = 3;
        run_job(8, 4, 1'b0, 1'b0, 0, 0);       // result 12
        data0 = 100; data1 = 5;
        run_job(8, 2, 1'b1, 1'b0, 0, 0);       // result 110
        run_job(8, 0, 1'b0, 1'b0, 0, 0);       // K=0
        data0 = 7;   data1 = 2;
        run_job(0, 3, 1'b0, 1'b0, 0, 0);       // C=0 acts as C=1
        stl[4] = 1'b1; stl[5] = 1'b1; stl[6] = 1'b1; stl[11] = 1'b1;
        run_job(8, 1, 1'b0, 1'b0, 0, 0);       // stalls on cycles 5-7, 12
        clear_stalls();
        run_job(8, 4, 1'b0, 1'b1, 20, 0);      // abort on cycle 20, start held
        run_job(8, 4, 1'b1, 1'b0, 0, 15);      // async reset on cycle 15
        run_job(4, 1, 1'b0, 1'b0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int c, k, ab;
            c = $urandom_range(0, 9);
            k = $urandom_range(0, 5);
            for (int i = 0; i < 512; i++) stl[i] = ($urandom_range(0, 4) == 0);
            data0 = $urandom_range(0, 65535);
            data1 = $urandom_range(0, 65535);
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 12) : 0;
            run_job(c, k, 1'($urandom), 1'($urandom), ab, 0);
        end

        repeat (3) @(posedge clk);
        #3 check("leftover_expected_events", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/acc_ctrl.md
Name: acc_ctrl

Overview:
Sequencer for the binary-serial PE accumulator. Drives its clr/en/acc controls so that one output accumulates K serial products, each taking C cycles. It optionally chains the upstream partial sum into the first product, and flags when the accumulated result is stable. One instance sits per PE column and is driven by the array scheduler through a start/done handshake.

Parameters:
CW, 5, width of cfg_cycles (serial cycles per product)
KW, 16, width of cfg_k (products per output)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
i_start  in  1  start request; accepted only in IDLE
i_cfg_cycles  in  CW  cycles per serial product (C); sampled on accept
i_cfg_k  in  KW  products to accumulate (K); sampled on accept
i_cfg_chain  in  1  1 = first product adds the upstream partial sum; sampled on accept
i_stall  in  1  freeze sequencing (operand starvation)
i_abort  in  1  cancel current job
o_clr  out  1  accumulator clear
o_en  out  1  accumulator update enable
o_acc  out  1  select upstream + product (1) or self + product (0)
o_busy  out  1  job in progress (state != IDLE)
o_valid  out  1  one-cycle pulse: accumulator output holds the final result

Behaviour:
- States: IDLE, CLR, RUN, DONE. The state and both counters are flops. Outputs are decoded combinationally from the state, the counters and i_stall.
- Reset: state=IDLE, counters=0, latched cfg=0. All outputs are 0 while in IDLE.
- IDLE: when i_start=1 at an edge, latch the cfg and go to CLR. i_start is ignored in every other state.
- C normalisation: latched C=0 is treated as C=1.
- CLR: lasts exactly one cycle with o_clr=1.
  - Next state is RUN if K>0.
  - Next state is DONE if K=0, so the job yields a zero result.
  - CLR ignores i_stall.
- RUN counters:
  - cyc counts 0..C-1 and wraps to 0.
  - kc counts completed products, 0..K-1.
  - Both counters advance only when i_stall=0.
- RUN outputs:
  - o_en = (cyc==C-1) && !i_stall.
  - o_acc = o_en && (kc==0) && cfg_chain.
  - o_clr=0.
- RUN exit: on an o_en cycle with kc==K-1, go to DONE. Otherwise, on cyc wrap, kc increments.
- DONE: one cycle with o_valid=1. The accumulator has already updated at the edge closing the last o_en cycle. Next state is IDLE, and a new i_start is accepted from the following IDLE cycle.
- Latency: with i_start accepted at edge 0 and no stalls:
  - CLR occupies cycle 1.
  - RUN occupies cycles 2..K*C+1.
  - o_en is high on cycles 1+j*C for j=1..K.
  - o_valid is high on cycle K*C+2.
  - Each stall cycle adds exactly one cycle.
- i_abort: in any non-IDLE state, next state is IDLE, counters clear, no o_valid is issued, and o_en/o_clr are forced 0 in that cycle. i_abort has priority over stall and over completion.
- Simultaneous stall with the final o_en: o_en is suppressed and completion is deferred until the first unstalled cycle.
- Reset mid-job: immediate return to IDLE. No further pulses.
- Widths: cyc is CW bits and kc is KW bits. There are no overflow cases, because comparisons use the latched values and K ≤ 2^KW-1.

Decomposition:
- Package acc_ctrl_pkg:
  - state enum typedef acc_ctrl_state_t {IDLE, CLR, RUN, DONE}.
  - Default CW/KW localparams.
- One sub-module, mod_cnt: a modulo counter with enable, sync clear, a max input and a wrap flag. It is instantiated for cyc (max C-1) and for kc (max K-1, enabled by cyc wrap).
- FSM and output decode stay in acc_ctrl.

Test Plan:
- Basic job, C=8, K=4, chain=0, start at edge 0:
  - o_clr on cycle 1.
  - o_en on cycles 9, 17, 25, 33, with o_acc=0.
  - o_valid on cycle 34.
  - Driving the accumulator with i_data1=3 gives output 12 at o_valid.
- Chaining, C=8, K=2, chain=1, i_data0=100, i_data1=5:
  - o_acc=1 only on cycle 9.
  - Accumulator output is 110 at o_valid (cycle 18).
- Degenerate configs:
  - K=0: o_clr on cycle 1, o_valid on cycle 2, no o_en.
  - C=0, K=3: behaves as C=1, with o_en on cycles 2, 3, 4 and o_valid on cycle 5.
- Stalls, C=8, K=1: i_stall high on cycles 5–7 and on cycle 12:
  - o_en moves from cycle 9 to cycle 13, suppressed on cycle 12.
  - o_valid on cycle 14.
- Abort and ignored start:
  - C=8, K=4, i_abort on cycle 20: o_busy drops on cycle 21, and no further o_en or o_valid.
  - i_start held high during the job is ignored; a new start accepted in IDLE reissues o_clr one cycle later.
- Asynchronous reset mid-RUN (cycle 15):
  - All outputs are 0 immediately, state is IDLE.
  - After release, a C=4, K=1 job completes with o_en on cycle 5 and o_valid on cycle 6.
